// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//  Definitions shared by the FIR frame bridge and the single-channel FIR core:
//  default address/data widths, default frame length and the bridge FSM states.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_ADDR_WIDTH = 16;
    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_N_SAMPLES  = 65536;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/fir_sample_ram.sv
// -----------------------------------------------------------------------------
// fir_sample_ram
//  Sample memory with one write port and one read port. The read port is
//  either combinational (ASYNC_READ=1) or registered with one cycle of latency
//  (ASYNC_READ=0). The sync variant returns the old contents on a same-address
//  read/write collision.
// Ports
//  clk      in   clock
//  we_i     in   write enable
//  waddr_i  in   write address
//  wdata_i  in   write data
//  raddr_i  in   read address
//  rdata_o  out  read data (same cycle or next cycle, per ASYNC_READ)
// -----------------------------------------------------------------------------
module fir_sample_ram
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter bit ASYNC_READ = 1'b1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing a RAM needs one write per word, so it would stop mapping to a memory macro.
    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    generate
        if (ASYNC_READ) begin : g_async_rd
            assign rdata_o = mem[raddr_i];
        end else begin : g_sync_rd
            logic [DATA_WIDTH-1:0] rdata_q;
            logic [DATA_WIDTH-1:0] rdata_d;

            always_comb begin
                rdata_d = mem[raddr_i];
            end

            always_ff @(posedge clk) begin
                rdata_q <= rdata_d;
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fir_frame_bridge.sv
// -----------------------------------------------------------------------------
// fir_frame_bridge
//  Host-side partner of the single-channel FIR core. Per frame it
//   LOAD : accepts N_SAMPLES samples from the upstream stream into in_ram,
//   RUN  : releases the FIR from reset and serves its memory port
//          (async reads from in_ram, result writes into out_ram),
//   DRAIN: after the FIR done interrupt, streams out_ram downstream through a
//          2-entry skid FIFO, then pulses frame_done_o and returns to IDLE.
// Ports
//  clk, rst                        clock, synchronous active-high reset
//  start_i                         begin a frame (IDLE only)
//  busy_o                          high in LOAD/RUN/DRAIN
//  frame_done_o                    1-cycle pulse after the last result beat
//  s_valid_i/s_ready_o/s_data_i    upstream sample stream
//  fir_rst_o                       FIR reset (high = held)
//  fir_addr_rd_i/fir_din_o         FIR read port into in_ram
//  fir_addr_wr_i/fir_dout_i/fir_we_i  FIR result write port into out_ram
//  fir_done_i                      FIR done interrupt (level)
//  m_valid_o/m_ready_i/m_data_o/m_last_o  downstream result stream
// -----------------------------------------------------------------------------
module fir_frame_bridge
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int N_SAMPLES  = FIR_N_SAMPLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  fir_rst_o,
    input  logic [ADDR_WIDTH-1:0] fir_addr_rd_i,
    output logic [DATA_WIDTH-1:0] fir_din_o,
    input  logic [ADDR_WIDTH-1:0] fir_addr_wr_i,
    input  logic [DATA_WIDTH-1:0] fir_dout_i,
    input  logic                  fir_we_i,
    input  logic                  fir_done_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    // One extra bit so a frame of exactly 2**ADDR_WIDTH samples ends without wrapping.
    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(N_SAMPLES);

    bridge_state_e         state_q,        state_d;
    logic [CNT_W-1:0]      load_cnt_q,     load_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q,       rd_cnt_d;
    logic                  rd_pend_q,      rd_pend_d;
    logic                  rd_pend_last_q, rd_pend_last_d;
    logic [1:0]            fifo_cnt_q,     fifo_cnt_d;
    logic [DATA_WIDTH-1:0] head_data_q,    head_data_d;
    logic [DATA_WIDTH-1:0] tail_data_q,    tail_data_d;
    logic                  head_last_q,    head_last_d;
    logic                  tail_last_q,    tail_last_d;
    logic                  busy_q,         busy_d;
    logic                  s_ready_q,      s_ready_d;
    logic                  fir_rst_q,      fir_rst_d;
    logic                  frame_done_q,   frame_done_d;

    logic                  s_fire;
    logic                  m_fire;
    logic                  out_we;
    logic                  rd_issue;
    logic [1:0]            fifo_after_pop;
    logic [1:0]            push_slot;
    logic [DATA_WIDTH-1:0] out_rdata;

    assign s_fire         = s_valid_i && s_ready_q;
    assign m_fire         = (fifo_cnt_q != 2'd0) && m_ready_i;
    // FIR writes are only honoured while it owns the result RAM.
    assign out_we         = (state_q == ST_RUN) && fir_we_i;
    assign fifo_after_pop = fifo_cnt_q - {1'b0, m_fire};
    // A new read must fit even if the in-flight read lands and nothing drains next cycle.
    assign rd_issue       = (state_q == ST_DRAIN) && (rd_cnt_q != FRAME_LEN)
                            && ((fifo_after_pop + {1'b0, rd_pend_q}) < 2'd2);

    fir_sample_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ASYNC_READ (1'b1)
    ) u_in_ram (
        .clk     (clk),
        .we_i    (s_fire),
        .waddr_i (load_cnt_q[ADDR_WIDTH-1:0]),
        .wdata_i (s_data_i),
        .raddr_i (fir_addr_rd_i),
        .rdata_o (fir_din_o)
    );

    fir_sample_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ASYNC_READ (1'b0)
    ) u_out_ram (
        .clk     (clk),
        .we_i    (out_we),
        .waddr_i (fir_addr_wr_i),
        .wdata_i (fir_dout_i),
        .raddr_i (rd_cnt_q[ADDR_WIDTH-1:0]),
        .rdata_o (out_rdata)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and infers a latch.
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        frame_done_d   = 1'b0;
        rd_pend_d      = rd_issue;
        rd_pend_last_d = (rd_cnt_q == LAST_IDX);
        fifo_cnt_d     = fifo_after_pop + {1'b0, rd_pend_q};
        head_data_d    = head_data_q;
        head_last_d    = head_last_q;
        tail_data_d    = tail_data_q;
        tail_last_d    = tail_last_q;
        push_slot      = fifo_after_pop;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (s_fire) begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                    if (load_cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fir_done_i) begin
                    state_d  = ST_DRAIN;
                    rd_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (m_fire && head_last_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Skid FIFO: head feeds m_*; a pop shifts tail into head and clears the
        // tail's last flag so an empty head never shows a stale m_last_o.
        if (m_fire) begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            tail_last_d = 1'b0;
        end
        if (rd_pend_q) begin
            if (push_slot == 2'd0) begin
                head_data_d = out_rdata;
                head_last_d = rd_pend_last_q;
            end else begin
                tail_data_d = out_rdata;
                tail_last_d = rd_pend_last_q;
            end
        end

        busy_d    = (state_d != ST_IDLE);
        s_ready_d = (state_d == ST_LOAD);
        fir_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            load_cnt_q     <= '0;
            rd_cnt_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            head_data_q    <= '0;
            head_last_q    <= 1'b0;
            tail_data_q    <= '0;
            tail_last_q    <= 1'b0;
            busy_q         <= 1'b0;
            s_ready_q      <= 1'b0;
            fir_rst_q      <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_last_q <= rd_pend_last_d;
            fifo_cnt_q     <= fifo_cnt_d;
            head_data_q    <= head_data_d;
            head_last_q    <= head_last_d;
            tail_data_q    <= tail_data_d;
            tail_last_q    <= tail_last_d;
            busy_q         <= busy_d;
            s_ready_q      <= s_ready_d;
            fir_rst_q      <= fir_rst_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign busy_o       = busy_q;
    assign s_ready_o    = s_ready_q;
    assign fir_rst_o    = fir_rst_q;
    assign frame_done_o = frame_done_q;
    assign m_valid_o    = (fifo_cnt_q != 2'd0);
    assign m_data_o     = head_data_q;
    assign m_last_o     = head_last_q;

endmodule

// File: tb/tb_fir_frame_bridge.sv
// -----------------------------------------------------------------------------
// tb_fir_frame_bridge
//  Directed bench for fir_frame_bridge with a 16-sample frame and a
//  behavioural FIR (dout = 2*din, last write and done together).
// -----------------------------------------------------------------------------
module tb_fir_frame_bridge;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NS = 16;

    typedef logic [DW-1:0] frame_t [NS];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          frame_done_o;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i = '0;
    logic          fir_rst_o;
    logic [AW-1:0] fir_addr_rd_i;
    logic [DW-1:0] fir_din_o;
    logic [AW-1:0] fir_addr_wr_i;
    logic [DW-1:0] fir_dout_i;
    logic          fir_we_i;
    logic          fir_done_i;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural FIR: after release it samples din at each edge, one edge
    // after presenting the address, and writes 2*din back to the same index.
    logic          mdl_we   = 1'b0;
    logic          mdl_done = 1'b0;
    logic [AW-1:0] mdl_rd   = '0;
    logic [AW-1:0] mdl_wr   = '0;
    logic [DW-1:0] mdl_dout = '0;

    always @(posedge clk) begin
        if (fir_rst_o) begin
            mdl_we   <= 1'b0;
            mdl_done <= 1'b0;
            mdl_rd   <= '0;
            mdl_wr   <= '0;
            mdl_dout <= '0;
        end else if (!mdl_done) begin
            mdl_we   <= 1'b1;
            mdl_wr   <= mdl_rd;
            mdl_dout <= {fir_din_o[DW-2:0], 1'b0};
            mdl_rd   <= mdl_rd + 1'b1;
            if (mdl_rd == AW'(NS - 1)) mdl_done <= 1'b1;
        end else begin
            mdl_we <= 1'b0;
        end
    end

    // Stray write injected on top of the model to probe write gating.
    logic          force_we   = 1'b0;
    logic [AW-1:0] force_addr = 4'd12;
    logic [DW-1:0] force_data = 16'hBEEF;

    assign fir_we_i      = mdl_we | force_we;
    assign fir_addr_wr_i = force_we ? force_addr : mdl_wr;
    assign fir_dout_i    = force_we ? force_data : mdl_dout;
    assign fir_addr_rd_i = mdl_rd;
    assign fir_done_i    = mdl_done;

    fir_frame_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_SAMPLES  (NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .fir_rst_o     (fir_rst_o),
        .fir_addr_rd_i (fir_addr_rd_i),
        .fir_din_o     (fir_din_o),
        .fir_addr_wr_i (fir_addr_wr_i),
        .fir_dout_i    (fir_dout_i),
        .fir_we_i      (fir_we_i),
        .fir_done_i    (fir_done_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_cmp++; if (fir_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_fir_rst got=%b exp=1", fir_rst_o); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid_o); end
        n_cmp++; if (m_last_o !== 1'b0) begin n_bad++; $display("FAIL reset_m_last got=%b exp=0", m_last_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_o); end
        rst = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1 || s_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL %s start busy=%b s_ready=%b exp=1/1", tag, busy_o, s_ready_o);
        end
    endtask

    task automatic load_frame(input frame_t vals, input bit gaps, input bit spam,
                              input bit inject, input string tag);
        int idx = 0;
        int cyc = 0;
        while (idx < NS && cyc < 400) begin
            @(negedge clk);
            s_valid_i = gaps ? (cyc % 3 != 1) : 1'b1;
            s_data_i  = vals[idx];
            start_i   = spam && (cyc % 4 == 2);
            force_we  = inject && (cyc == 2);
            if (s_valid_i && s_ready_o) idx++;
            cyc++;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        force_we  = 1'b0;
        n_cmp++; if (idx != NS) begin n_bad++; $display("FAIL %s load_timeout beats=%0d exp=%0d", tag, idx, NS); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL %s load_ready_drop got=%b exp=0", tag, s_ready_o); end
        n_cmp++; if (fir_rst_o !== 1'b0) begin n_bad++; $display("FAIL %s run_fir_release got=%b exp=0", tag, fir_rst_o); end
    endtask

    task automatic drain_frame(input frame_t exp, input bit stalls, input bit spam,
                               input bit inject, input string tag);
        int cyc = 0;
        int entry;
        int first = -1;
        int last_cyc = 0;
        int idx = 0;
        int done_early = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] held = '0;

        while (!(busy_o && fir_rst_o) && cyc < 200) begin
            start_i = spam && (cyc % 4 == 1);
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (!(busy_o && fir_rst_o)) begin
            n_bad++; $display("FAIL %s drain_entry_timeout busy=%b fir_rst=%b exp=1/1", tag, busy_o, fir_rst_o);
        end

        entry = cyc;
        while (idx < NS && cyc < entry + 400) begin
            m_ready_i = stalls ? (cyc % 3 != 0) : 1'b1;
            start_i   = spam && (cyc % 4 == 1);
            force_we  = inject && (cyc == entry);
            if (stalled) begin
                n_cmp++; if (m_valid_o !== 1'b1 || m_data_o !== held) begin
                    n_bad++; $display("FAIL %s stall_hold valid=%b data=%h exp=1/%h", tag, m_valid_o, m_data_o, held);
                end
            end
            stalled = 1'b0;
            if (frame_done_o) done_early++;
            if (m_valid_o) begin
                if (first < 0) first = cyc;
                if (m_ready_i) begin
                    n_cmp++; if (m_data_o !== exp[idx]) begin
                        n_bad++; $display("FAIL %s beat%0d data got=%h exp=%h", tag, idx, m_data_o, exp[idx]);
                    end
                    n_cmp++; if (m_last_o !== (idx == NS - 1)) begin
                        n_bad++; $display("FAIL %s beat%0d last got=%b exp=%b", tag, idx, m_last_o, (idx == NS - 1));
                    end
                    last_cyc = cyc;
                    idx++;
                end else begin
                    stalled = 1'b1;
                    held    = m_data_o;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_ready_i = 1'b0;
        start_i   = 1'b0;
        force_we  = 1'b0;

        n_cmp++; if (idx != NS) begin n_bad++; $display("FAIL %s drain_timeout beats=%0d exp=%0d", tag, idx, NS); end
        n_cmp++; if (first < 0 || first - entry > 2) begin
            n_bad++; $display("FAIL %s first_valid_latency got=%0d exp<=2", tag, first - entry);
        end
        if (!stalls) begin
            n_cmp++; if (last_cyc - first != NS - 1) begin
                n_bad++; $display("FAIL %s back_to_back span=%0d exp=%0d", tag, last_cyc - first, NS - 1);
            end
        end
        n_cmp++; if (done_early != 0) begin n_bad++; $display("FAIL %s early_frame_done count=%0d exp=0", tag, done_early); end
        n_cmp++; if (frame_done_o !== 1'b1) begin n_bad++; $display("FAIL %s frame_done_pulse got=%b exp=1", tag, frame_done_o); end
        @(negedge clk);
        n_cmp++; if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL %s idle_after_frame done=%b busy=%b exp=0/0", tag, frame_done_o, busy_o);
        end
    endtask

    task automatic test_basic();
        frame_t vals;
        frame_t exp;
        for (int i = 0; i < NS; i++) begin
            vals[i] = DW'(i);
            exp[i]  = DW'(2 * i);
        end
        pulse_start("basic");
        load_frame(vals, 1'b0, 1'b0, 1'b0, "basic");
        drain_frame(exp, 1'b0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_gaps_stalls();
        frame_t vals;
        frame_t exp;
        for (int i = 0; i < NS; i++) begin
            vals[i] = 16'h0100 + DW'(37 * i);
            exp[i]  = 16'h0200 + DW'(74 * i);
        end
        pulse_start("stall");
        load_frame(vals, 1'b1, 1'b0, 1'b0, "stall");
        drain_frame(exp, 1'b1, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_start_ignored();
        frame_t vals;
        frame_t exp;
        for (int i = 0; i < NS; i++) begin
            vals[i] = 16'hFFFF - DW'(i);
            exp[i]  = 16'hFFFE - DW'(2 * i);
        end
        pulse_start("spam");
        load_frame(vals, 1'b0, 1'b1, 1'b0, "spam");
        drain_frame(exp, 1'b1, 1'b1, 1'b0, "spam");
        repeat (4) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL spam one_frame_only busy=%b exp=0", busy_o); end
    endtask

    task automatic test_reset_mid_run();
        frame_t vals;
        frame_t exp;
        int cyc = 0;
        for (int i = 0; i < NS; i++) begin
            vals[i] = DW'(5 * i + 1);
        end
        pulse_start("rmr");
        load_frame(vals, 1'b0, 1'b0, 1'b0, "rmr");
        while (!(mdl_we && mdl_wr == 4'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (!(mdl_we && mdl_wr == 4'd4)) begin
            n_bad++; $display("FAIL rmr fifth_write_timeout we=%b wr=%0d exp=1/4", mdl_we, mdl_wr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (fir_rst_o !== 1'b1) begin n_bad++; $display("FAIL rmr fir_rst got=%b exp=1", fir_rst_o); end
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmr m_valid got=%b exp=0", m_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rmr busy got=%b exp=0", busy_o); end
        n_cmp++; if (s_ready_o !== 1'b0) begin n_bad++; $display("FAIL rmr s_ready got=%b exp=0", s_ready_o); end

        // Fresh frame, including values whose doubling overflows 16 bits.
        for (int i = 0; i < NS; i++) begin
            vals[i] = 16'h8001 + DW'(i);
            exp[i]  = 16'h0002 + DW'(2 * i);
        end
        pulse_start("rmr2");
        load_frame(vals, 1'b0, 1'b0, 1'b0, "rmr2");
        drain_frame(exp, 1'b0, 1'b0, 1'b0, "rmr2");
    endtask

    task automatic test_we_outside_run();
        frame_t vals;
        frame_t exp;
        for (int i = 0; i < NS; i++) begin
            vals[i] = DW'(3 * i);
            exp[i]  = DW'(6 * i);
        end
        // Stray writes to address 12 in LOAD and at DRAIN entry (before it is read back).
        pulse_start("we");
        load_frame(vals, 1'b0, 1'b0, 1'b1, "we");
        drain_frame(exp, 1'b1, 1'b0, 1'b1, "we");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps_stalls();
        test_start_ignored();
        test_reset_mid_run();
        test_we_outside_run();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
